mem_port_arbiter: RTL and testbench

//  Merges the CPU core's two SRAM-like master ports (inst_*, data_*) onto one downstream

---
 rtl/mem_port_arbiter_if.sv | 54 +++++
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 tb/tb_mem_port_arbiter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two CPU-side SRAM-like ports, the merged downstream port and the error flag.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface mem_port_arbiter_if;
    logic        inst_req;
    logic        inst_cache;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic        data_cache;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [2:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic        m_req;
    logic        m_cache;
    logic        m_wr;
    logic [3:0]  m_wstrb;
    logic [2:0]  m_size;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_addr_ok;
    logic        m_data_ok;
    logic [31:0] m_rdata;

    logic        protocol_err;

    modport slave (
        input  inst_req, inst_cache, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_cache, data_wr, data_wstrb, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output m_req, m_cache, m_wr, m_wstrb, m_size, m_addr, m_wdata,
        input  m_addr_ok, m_data_ok, m_rdata,
        output protocol_err
    );

    modport master (
        output inst_req, inst_cache, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_cache, data_wr, data_wstrb, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  m_req, m_cache, m_wr, m_wstrb, m_size, m_addr, m_wdata,
        output m_addr_ok, m_data_ok, m_rdata,
        input  protocol_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Merges the inst and data SRAM-like ports onto one downstream port, zero added latency,
// steering in-order responses back through a small issue-order FIFO (1 = data).
module mem_port_arbiter #(
    parameter int DEPTH     = 4,
    parameter bit DATA_PRIO = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] r_order;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_lock_v;
    logic             r_lock_src;
    logic             r_rr_last;
    logic             r_protocol_err;

    logic             w_full;
    logic             w_empty;
    logic             w_any_req;
    logic             w_lock_req;
    logic             w_grant;
    logic             w_m_req;
    logic             w_accept;
    logic             w_pop;
    logic             w_head;
    logic [DEPTH-1:0] w_order_next;

    assign w_full     = (r_count == (AW+1)'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_any_req  = bus.inst_req | bus.data_req;
    assign w_lock_req = r_lock_src ? bus.data_req : bus.inst_req;

    always_comb begin
        w_grant = 1'b0;
        if (r_lock_v && w_lock_req) begin
            w_grant = r_lock_src;
        end else if (bus.data_req && !bus.inst_req) begin
            w_grant = 1'b1;
        end else if (bus.data_req && bus.inst_req) begin
            w_grant = DATA_PRIO ? 1'b1 : ~r_rr_last;
        end
    end

    assign w_m_req  = w_any_req & ~w_full;
    assign w_accept = w_m_req & bus.m_addr_ok;
    assign w_pop    = bus.m_data_ok & ~w_empty;
    assign w_head   = r_order[r_rd_ptr];

    // Inst grants carry a fixed word-size read payload.
    assign bus.m_req   = w_m_req;
    assign bus.m_cache = w_grant ? bus.data_cache : bus.inst_cache;
    assign bus.m_wr    = w_grant ? bus.data_wr    : 1'b0;
    assign bus.m_wstrb = w_grant ? bus.data_wstrb : 4'd0;
    assign bus.m_size  = w_grant ? bus.data_size  : 3'd2;
    assign bus.m_addr  = w_grant ? bus.data_addr  : bus.inst_addr;
    assign bus.m_wdata = w_grant ? bus.data_wdata : 32'd0;

    assign bus.inst_addr_ok = w_accept & ~w_grant;
    assign bus.data_addr_ok = w_accept &  w_grant;
    assign bus.inst_data_ok = w_pop & ~w_head;
    assign bus.data_data_ok = w_pop &  w_head;
    assign bus.inst_rdata   = bus.m_rdata;
    assign bus.data_rdata   = bus.m_rdata;
    assign bus.protocol_err = r_protocol_err;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_order
            assign w_order_next[gi] = (w_accept && (r_wr_ptr == AW'(gi))) ? w_grant : r_order[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_order        <= '0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_lock_v       <= 1'b0;
            r_lock_src     <= 1'b0;
            r_rr_last      <= 1'b0;
            r_protocol_err <= 1'b0;
        end else begin
            r_order <= w_order_next;
            if (w_accept) begin
                r_wr_ptr  <= r_wr_ptr + AW'(1);
                r_rr_last <= w_grant;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (bus.m_data_ok && w_empty) begin
                r_protocol_err <= 1'b1;
            end
            // Hold the grant across a downstream stall; release on accept or cancellation.
            if (w_m_req) begin
                r_lock_v <= ~bus.m_addr_ok;
                if (!bus.m_addr_ok) begin
                    r_lock_src <= w_grant;
                end
            end else if (r_lock_v && !w_lock_req) begin
                r_lock_v <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives a round-robin and a data-priority arbiter with identical stimulus and checks both
// against a queue-based model of the issue order, lock and arbitration rules.
module tb_mem_port_arbiter;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        inst_req, inst_cache, data_req, data_cache, data_wr, m_addr_ok, m_data_ok;
    logic [31:0] inst_addr, data_addr, data_wdata, m_rdata;
    logic [3:0]  data_wstrb;
    logic [2:0]  data_size;

    mem_port_arbiter_if b0 ();
    mem_port_arbiter_if b1 ();

    assign b0.inst_req = inst_req;     assign b1.inst_req = inst_req;
    assign b0.inst_cache = inst_cache; assign b1.inst_cache = inst_cache;
    assign b0.inst_addr = inst_addr;   assign b1.inst_addr = inst_addr;
    assign b0.data_req = data_req;     assign b1.data_req = data_req;
    assign b0.data_cache = data_cache; assign b1.data_cache = data_cache;
    assign b0.data_wr = data_wr;       assign b1.data_wr = data_wr;
    assign b0.data_wstrb = data_wstrb; assign b1.data_wstrb = data_wstrb;
    assign b0.data_size = data_size;   assign b1.data_size = data_size;
    assign b0.data_addr = data_addr;   assign b1.data_addr = data_addr;
    assign b0.data_wdata = data_wdata; assign b1.data_wdata = data_wdata;
    assign b0.m_addr_ok = m_addr_ok;   assign b1.m_addr_ok = m_addr_ok;
    assign b0.m_data_ok = m_data_ok;   assign b1.m_data_ok = m_data_ok;
    assign b0.m_rdata = m_rdata;       assign b1.m_rdata = m_rdata;

    mem_port_arbiter #(.DEPTH(DEPTH), .DATA_PRIO(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
    mem_port_arbiter #(.DEPTH(DEPTH), .DATA_PRIO(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(b1));

    logic [5:0]  ctl [2];
    logic [8:0]  pay [2];
    logic [31:0] maddr [2], mwdata [2], irdata [2], drdata [2];
    logic [3:0]  cnt [2];
    assign ctl[0] = {b0.m_req, b0.inst_addr_ok, b0.data_addr_ok, b0.inst_data_ok, b0.data_data_ok, b0.protocol_err};
    assign ctl[1] = {b1.m_req, b1.inst_addr_ok, b1.data_addr_ok, b1.inst_data_ok, b1.data_data_ok, b1.protocol_err};
    assign pay[0] = {b0.m_cache, b0.m_wr, b0.m_wstrb, b0.m_size};
    assign pay[1] = {b1.m_cache, b1.m_wr, b1.m_wstrb, b1.m_size};
    assign maddr[0] = b0.m_addr;   assign maddr[1] = b1.m_addr;
    assign mwdata[0] = b0.m_wdata; assign mwdata[1] = b1.m_wdata;
    assign irdata[0] = b0.inst_rdata; assign irdata[1] = b1.inst_rdata;
    assign drdata[0] = b0.data_rdata; assign drdata[1] = b1.data_rdata;
    assign cnt[0] = 4'(dut0.r_count);
    assign cnt[1] = 4'(dut1.r_count);

    // Reference model: outstanding issue order as a queue, plus lock / round-robin memory.
    bit q0 [$];
    bit q1 [$];
    bit lock_v [2], lock_src [2], rr_last [2], perr [2];
    bit e_g [2], e_mreq [2], e_acc [2], e_pop [2];
    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic int qsz(int p);
        return (p == 1) ? q1.size() : q0.size();
    endfunction

    function automatic bit qhd(int p);
        return (p == 1) ? q1[0] : q0[0];
    endfunction

    function automatic bit model_grant(int p);
        if (lock_v[p] && (lock_src[p] ? data_req : inst_req)) return lock_src[p];
        if (inst_req && data_req) return (p == 1) ? 1'b1 : !rr_last[p];
        return data_req;
    endfunction

    task automatic check_port(int p);
        bit g, hd;
        logic [8:0] epay;
        g = model_grant(p);
        e_g[p]    = g;
        e_mreq[p] = (inst_req || data_req) && (qsz(p) < DEPTH);
        e_acc[p]  = e_mreq[p] && m_addr_ok;
        e_pop[p]  = m_data_ok && (qsz(p) > 0);
        hd = e_pop[p] ? qhd(p) : 1'b0;
        chk($sformatf("ctl%0d", p), 32'(ctl[p]),
            32'({e_mreq[p], e_acc[p] && !g, e_acc[p] && g, e_pop[p] && !hd, e_pop[p] && hd, perr[p]}));
        chk($sformatf("count%0d", p), 32'(cnt[p]), 32'(qsz(p)));
        chk($sformatf("irdata%0d", p), irdata[p], m_rdata);
        chk($sformatf("drdata%0d", p), drdata[p], m_rdata);
        if (e_mreq[p]) begin
            epay = g ? {data_cache, data_wr, data_wstrb, data_size} : {inst_cache, 1'b0, 4'd0, 3'd2};
            chk($sformatf("payload%0d", p), 32'(pay[p]), 32'(epay));
            chk($sformatf("m_addr%0d", p), maddr[p], g ? data_addr : inst_addr);
            chk($sformatf("m_wdata%0d", p), mwdata[p], g ? data_wdata : 32'd0);
        end
    endtask

    task automatic update_port(int p);
        bit hd;
        if (m_data_ok && qsz(p) == 0) perr[p] = 1'b1;
        if (e_pop[p]) begin
            hd = qhd(p);
            if (p == 1) void'(q1.pop_front()); else void'(q0.pop_front());
            if (p == 1) $display("cyc %0d prio1 response -> %s rdata=%h", cyc, hd ? "data" : "inst", m_rdata);
        end
        if (e_acc[p]) begin
            if (p == 1) q1.push_back(e_g[p]); else q0.push_back(e_g[p]);
            rr_last[p] = e_g[p];
            if (p == 1) $display("cyc %0d prio1 accept %s addr=%h", cyc, e_g[p] ? "data" : "inst",
                                 e_g[p] ? data_addr : inst_addr);
        end
        if (e_mreq[p]) begin
            lock_v[p] = !m_addr_ok;
            if (!m_addr_ok) lock_src[p] = e_g[p];
        end else if (lock_v[p] && !(lock_src[p] ? data_req : inst_req)) begin
            lock_v[p] = 1'b0;
        end
    endtask

    task automatic settle();
        #1;
        check_port(0);
        check_port(1);
    endtask

    task automatic tick();
        @(posedge clk);
        update_port(0);
        update_port(1);
        cyc++;
        #1;
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    task automatic idle_inputs();
        inst_req = 0; inst_cache = 0; inst_addr = 0;
        data_req = 0; data_cache = 0; data_wr = 0; data_wstrb = 0; data_size = 0;
        data_addr = 0; data_wdata = 0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        q0.delete(); q1.delete();
        for (int p = 0; p < 2; p++) begin
            lock_v[p] = 0; lock_src[p] = 0; rr_last[p] = 0; perr[p] = 0;
            chk($sformatf("rst_count%0d", p), 32'(cnt[p]), 32'd0);
            chk($sformatf("rst_perr%0d", p), 32'(ctl[p][0]), 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain(int n);
        inst_req = 0; data_req = 0; m_addr_ok = 0;
        for (int i = 0; i < n; i++) begin
            m_data_ok = 1; m_rdata = $urandom;
            step();
        end
        m_data_ok = 0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        do_reset();

        // 1: single inst request and its response
        inst_req = 1; inst_addr = 32'h0000_1000; m_addr_ok = 1;
        settle();
        chk("t1_inst_addr_ok", 32'(b1.inst_addr_ok), 32'd1);
        tick();
        inst_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h1234_5678;
        settle();
        chk("t1_inst_data_ok", 32'(b1.inst_data_ok), 32'd1);
        chk("t1_inst_rdata", b1.inst_rdata, 32'h1234_5678);
        chk("t1_data_data_ok", 32'(b1.data_data_ok), 32'd0);
        tick();
        m_data_ok = 0;

        // 2: both requesting: fixed priority vs round robin
        inst_req = 1; data_req = 1; m_addr_ok = 1; inst_addr = 32'h2000; data_addr = 32'h3000;
        data_size = 3'd2; data_cache = 1;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("t2_prio_data", 32'(b1.data_addr_ok), 32'd1);
            chk("t2_prio_inst", 32'(b1.inst_addr_ok), 32'd0);
            chk("t2_rr_data", 32'(b0.data_addr_ok), (k == 1) ? 32'd0 : 32'd1);
            chk("t2_rr_inst", 32'(b0.inst_addr_ok), (k == 1) ? 32'd1 : 32'd0);
            tick();
        end
        drain(3);

        // 3: stalled inst grant holds m_addr until accepted
        do_reset();
        inst_req = 1; inst_addr = 32'hA000_0040; data_addr = 32'hD000_0080; m_addr_ok = 0;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) data_req = 1;
            settle();
            chk("t3_addr_stable", b1.m_addr, 32'hA000_0040);
            tick();
        end
        m_addr_ok = 1;
        settle();
        chk("t3_inst_accept", 32'(b1.inst_addr_ok), 32'd1);
        tick();
        inst_req = 0;
        settle();
        chk("t3_data_next", 32'(b1.data_addr_ok), 32'd1);
        tick();
        drain(2);

        // 4: FIFO full blocks requests; pop + pending req refills
        do_reset();
        inst_req = 1; m_addr_ok = 1;
        for (int k = 0; k < 4; k++) begin
            inst_addr = 32'h100 + 32'(k * 4);
            step();
        end
        chk("t4_count_full", 32'(cnt[1]), 32'd4);
        data_req = 1;
        settle();
        chk("t4_full_mreq", 32'(b1.m_req), 32'd0);
        chk("t4_full_aok", 32'({b1.inst_addr_ok, b1.data_addr_ok}), 32'd0);
        tick();
        m_data_ok = 1;
        step();
        m_data_ok = 0;
        settle();
        chk("t4_refill", 32'(b1.data_addr_ok), 32'd1);
        tick();
        chk("t4_count_still", 32'(cnt[1]), 32'd4);
        drain(4);

        // 5: I, D, I, D(store) order steering, three rounds to wrap pointers
        for (int r = 0; r < 3; r++) begin
            m_addr_ok = 1;
            for (int k = 0; k < 4; k++) begin
                inst_req = (k % 2 == 0); data_req = (k % 2 == 1);
                inst_addr = 32'h4000 + 32'(k); data_addr = 32'h5000 + 32'(k);
                data_wr = (k == 3); data_wstrb = (k == 3) ? 4'hF : 4'h0;
                data_wdata = $urandom;
                step();
            end
            inst_req = 0; data_req = 0; m_addr_ok = 0; data_wr = 0; data_wstrb = 0;
            for (int k = 0; k < 4; k++) begin
                m_data_ok = 1; m_rdata = $urandom;
                settle();
                chk("t5_order_inst", 32'(b1.inst_data_ok), (k % 2 == 0) ? 32'd1 : 32'd0);
                chk("t5_order_data", 32'(b1.data_data_ok), (k % 2 == 1) ? 32'd1 : 32'd0);
                tick();
            end
            m_data_ok = 0;
        end

        // 6: response with empty FIFO, then reset mid-burst
        m_data_ok = 1;
        settle();
        chk("t6_no_pulse", 32'({b1.inst_data_ok, b1.data_data_ok}), 32'd0);
        tick();
        m_data_ok = 0;
        settle();
        chk("t6_perr", 32'(b1.protocol_err), 32'd1);
        tick();
        inst_req = 1; m_addr_ok = 1;
        step(); step();
        chk("t6_count2", 32'(cnt[1]), 32'd2);
        inst_req = 0; m_addr_ok = 0;
        do_reset();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            inst_req = ($urandom_range(0, 2) != 0);
            data_req = ($urandom_range(0, 2) != 0);
            inst_cache = $urandom; inst_addr = $urandom;
            data_cache = $urandom; data_wr = $urandom; data_wstrb = 4'($urandom);
            data_size = 3'($urandom); data_addr = $urandom; data_wdata = $urandom;
            m_addr_ok = $urandom;
            m_data_ok = (qsz(1) > 0) && ($urandom_range(0, 1) == 1);
            m_rdata = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
